// File: rtl/chroma_dc_insert_p.sv
// Chroma DC insertion for the MB stream: passes 4x4 blocks through zero-extended,
// then appends a CbDC word and a CrDC word built from per-block pel sums.
module chroma_dc_insert_p #(
    parameter int PEL_W     = 8,
    parameter int OUT_W     = 16,
    parameter bit ALLOW_422 = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 mode_422,
    input  logic [16*PEL_W-1:0]  s_data,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic                 s_last,
    output logic [16*OUT_W-1:0]  m_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 m_last,
    output logic                 sync_err
);

    localparam int DC_W = PEL_W + 4;

    localparam logic [1:0] S_PASS = 2'd0;
    localparam logic [1:0] S_CBDC = 2'd1;
    localparam logic [1:0] S_CRDC = 2'd2;

    generate
        if (OUT_W < PEL_W + 4) begin : g_bad_width
            $error("chroma_dc_insert_p: OUT_W must be >= PEL_W+4");
        end
    endgenerate

    logic [1:0]                 state_q, state_d;
    logic [4:0]                 blk_cnt_q, blk_cnt_d;
    logic                       mb422_q, mb422_d;
    logic [7:0][DC_W-1:0]       cb_dc_q, cb_dc_d;
    logic [7:0][DC_W-1:0]       cr_dc_q, cr_dc_d;
    logic [16*OUT_W-1:0]        m_data_q, m_data_d;
    logic                       m_valid_q, m_valid_d;
    logic                       m_last_q, m_last_d;
    logic                       sync_err_q, sync_err_d;

    logic                       out_free;
    logic                       acc;
    logic                       nc8;
    logic                       at_last;
    logic                       is_cb;
    logic                       mb_end;
    logic [2:0]                 cb_idx;
    logic [2:0]                 cr_idx;
    logic [DC_W-1:0]            dc_sum;
    logic [16*OUT_W-1:0]        pass_word;
    logic [16*OUT_W-1:0]        cb_word;
    logic [16*OUT_W-1:0]        cr_word;

    assign out_free = !m_valid_q || m_ready;
    assign s_ready  = (state_q == S_PASS) && out_free;
    assign acc      = s_valid && s_ready;

    // Block 0 uses the live mode bit so the MB length is right from its first beat.
    assign nc8     = ALLOW_422 && ((blk_cnt_q == 5'd0) ? mode_422 : mb422_q);
    assign at_last = (blk_cnt_q == (nc8 ? 5'd31 : 5'd23));
    assign is_cb   = blk_cnt_q[4] && (blk_cnt_q < (nc8 ? 5'd24 : 5'd20));
    assign mb_end  = s_last || at_last;
    assign cb_idx  = blk_cnt_q[2:0];
    assign cr_idx  = nc8 ? blk_cnt_q[2:0] : (blk_cnt_q[2:0] - 3'd4);

    always_comb begin
        dc_sum = '0;
        for (int k = 0; k < 16; k++) begin
            dc_sum = dc_sum + DC_W'(s_data[k*PEL_W +: PEL_W]);
        end
    end

    for (genvar k = 0; k < 16; k++) begin : g_lane
        assign pass_word[k*OUT_W +: OUT_W] = OUT_W'(s_data[k*PEL_W +: PEL_W]);
        if (k < 8) begin : g_dc
            assign cb_word[k*OUT_W +: OUT_W] = OUT_W'(cb_dc_q[k]);
            assign cr_word[k*OUT_W +: OUT_W] = OUT_W'(cr_dc_q[k]);
        end else begin : g_zero
            assign cb_word[k*OUT_W +: OUT_W] = '0;
            assign cr_word[k*OUT_W +: OUT_W] = '0;
        end
    end

    always_comb begin
        state_d    = state_q;
        blk_cnt_d  = blk_cnt_q;
        mb422_d    = mb422_q;
        cb_dc_d    = cb_dc_q;
        cr_dc_d    = cr_dc_q;
        m_data_d   = m_data_q;
        m_valid_d  = m_valid_q;
        m_last_d   = m_last_q;
        sync_err_d = 1'b0;
        // Output slot drains this cycle; a load below may refill it.
        if (out_free) begin
            m_valid_d = 1'b0;
            m_last_d  = 1'b0;
        end
        case (state_q)
            S_PASS: begin
                if (acc) begin
                    m_data_d  = pass_word;
                    m_valid_d = 1'b1;
                    m_last_d  = 1'b0;
                    if (blk_cnt_q == 5'd0) mb422_d = ALLOW_422 && mode_422;
                    if (is_cb)             cb_dc_d[cb_idx] = dc_sum;
                    else if (blk_cnt_q[4]) cr_dc_d[cr_idx] = dc_sum;
                    sync_err_d = s_last ^ at_last;
                    if (mb_end) state_d   = S_CBDC;
                    else        blk_cnt_d = blk_cnt_q + 5'd1;
                end
            end
            S_CBDC: begin
                if (out_free) begin
                    m_data_d  = cb_word;
                    m_valid_d = 1'b1;
                    m_last_d  = 1'b0;
                    state_d   = S_CRDC;
                end
            end
            S_CRDC: begin
                if (out_free) begin
                    m_data_d  = cr_word;
                    m_valid_d = 1'b1;
                    m_last_d  = 1'b1;
                    state_d   = S_PASS;
                    blk_cnt_d = '0;
                    cb_dc_d   = '0;
                    cr_dc_d   = '0;
                end
            end
            default: state_d = S_PASS;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_PASS;
            blk_cnt_q  <= '0;
            mb422_q    <= 1'b0;
            cb_dc_q    <= '0;
            cr_dc_q    <= '0;
            m_data_q   <= '0;
            m_valid_q  <= 1'b0;
            m_last_q   <= 1'b0;
            sync_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            blk_cnt_q  <= blk_cnt_d;
            mb422_q    <= mb422_d;
            cb_dc_q    <= cb_dc_d;
            cr_dc_q    <= cr_dc_d;
            m_data_q   <= m_data_d;
            m_valid_q  <= m_valid_d;
            m_last_q   <= m_last_d;
            sync_err_q <= sync_err_d;
        end
    end

    assign m_data   = m_data_q;
    assign m_valid  = m_valid_q;
    assign m_last   = m_last_q;
    assign sync_err = sync_err_q;

endmodule

// File: tb/tb_chroma_dc_insert_p.sv
// Directed bench for chroma_dc_insert_p: drives whole MBs, scoreboards every output
// beat against a stream model and spot-checks hand-computed DC lanes.
module tb_chroma_dc_insert_p;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         mode_422;
    logic [127:0] s_data;
    logic         s_valid;
    logic         s_ready;
    logic         s_last;
    logic [255:0] m_data;
    logic         m_valid;
    logic         m_ready;
    logic         m_last;
    logic         sync_err;

    chroma_dc_insert_p #(.PEL_W(8), .OUT_W(16), .ALLOW_422(1'b1)) dut (
        .clk(clk), .reset_n(reset_n), .mode_422(mode_422),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready), .s_last(s_last),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
        .sync_err(sync_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int tick = 0;
    int serr_cnt, sready_bad, first_acc;
    bit timeout;

    logic [127:0] in_data[$];
    bit           in_last[$];
    bit           in_end[$];
    logic [255:0] out_data[$];
    bit           out_last[$];
    int           out_tick[$];
    logic [255:0] exp_data[$];
    bit           exp_last[$];

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] blk(input logic [7:0] p);
        logic [127:0] r;
        for (int k = 0; k < 16; k++) r[k*8 +: 8] = p;
        return r;
    endfunction

    function automatic int lane(input logic [255:0] d, input int k);
        return int'(d[k*16 +: 16]);
    endfunction

    task automatic add_beat(input logic [127:0] d, input bit last, input bit endf);
        in_data.push_back(d);
        in_last.push_back(last);
        in_end.push_back(endf);
    endtask

    // 4:2:0 MB: luma 0x10, Cb block k = k+1, Cr 0x80; s_last on the final beat.
    task automatic add_mb420();
        for (int i = 0; i < 16; i++) add_beat(blk(8'h10), 1'b0, 1'b0);
        for (int k = 0; k < 4; k++)  add_beat(blk(8'(k + 1)), 1'b0, 1'b0);
        for (int k = 0; k < 4; k++)  add_beat(blk(8'h80), (k == 3), (k == 3));
    endtask

    // Stream model: zero-extended pass-through, DC words after each MB end.
    task automatic build_model(input int nc);
        logic [7:0][15:0] cb, cr;
        int pos, sum;
        exp_data.delete(); exp_last.delete();
        cb = '0; cr = '0; pos = 0;
        for (int i = 0; i < in_data.size(); i++) begin
            logic [255:0] w;
            w = '0; sum = 0;
            for (int k = 0; k < 16; k++) begin
                w[k*16 +: 16] = {8'h00, in_data[i][k*8 +: 8]};
                sum += int'(in_data[i][k*8 +: 8]);
            end
            exp_data.push_back(w); exp_last.push_back(1'b0);
            if (pos >= 16 && pos < 16 + nc) cb[pos-16] = 16'(sum);
            else if (pos >= 16 + nc)        cr[pos-16-nc] = 16'(sum);
            if (in_end[i]) begin
                exp_data.push_back({128'h0, cb}); exp_last.push_back(1'b0);
                exp_data.push_back({128'h0, cr}); exp_last.push_back(1'b1);
                cb = '0; cr = '0; pos = 0;
            end else begin
                pos++;
            end
        end
    endtask

    task automatic sample_out();
        if (m_valid && m_ready) begin
            out_data.push_back(m_data);
            out_last.push_back(m_last);
            out_tick.push_back(tick);
        end
        if (sync_err) serr_cnt++;
    endtask

    task automatic run_stream(input bit rnd, input bit mode0, input bit mode1);
        int idx, budget, after;
        bit vld;
        idx = 0; budget = 0; after = 0;
        out_data.delete(); out_last.delete(); out_tick.delete();
        serr_cnt = 0; sready_bad = 0; first_acc = -1; timeout = 1'b0;
        while ((idx < in_data.size() || out_data.size() < exp_data.size()) && !timeout) begin
            vld      = (idx < in_data.size()) && (!rnd || $urandom_range(0, 3) != 0);
            s_valid  = vld;
            s_data   = vld ? in_data[idx] : '0;
            s_last   = vld ? in_last[idx] : 1'b0;
            mode_422 = (idx == 0) ? mode0 : mode1;
            m_ready  = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
            @(negedge clk);
            sample_out();
            if (after > 0) begin
                if (s_ready) sready_bad++;
                after--;
            end
            if (s_valid && s_ready) begin
                if (first_acc < 0) first_acc = tick;
                if (in_end[idx]) after = 2;
                idx++;
            end
            tick++;
            budget++;
            if (budget > 3000) timeout = 1'b1;
            @(posedge clk); #1;
        end
        s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b1;
        repeat (4) begin
            @(negedge clk);
            sample_out();
            tick++;
            @(posedge clk); #1;
        end
    endtask

    task automatic compare_all(input string tag);
        int bad;
        bad = 0;
        chk({tag, "_timeout"}, int'(timeout), 0);
        chk({tag, "_beats"}, out_data.size(), exp_data.size());
        for (int i = 0; i < exp_data.size() && i < out_data.size(); i++)
            if (out_data[i] !== exp_data[i] || out_last[i] !== exp_last[i]) bad++;
        chk({tag, "_bad_beats"}, bad, 0);
    endtask

    function automatic int count_last();
        int n;
        n = 0;
        foreach (out_last[i]) if (out_last[i]) n++;
        return n;
    endfunction

    initial begin
        reset_n = 1'b0; mode_422 = 1'b0; s_data = '0; s_valid = 1'b0;
        s_last = 1'b0; m_ready = 1'b0;
        #1;
        chk("rst_m_valid", int'(m_valid), 0);
        chk("rst_m_last", int'(m_last), 0);
        chk("rst_m_data_lane0", lane(m_data, 0), 0);
        chk("rst_sync_err", int'(sync_err), 0);
        chk("rst_s_ready", int'(s_ready), 1);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;

        // 1: 4:2:0 at full rate
        in_data.delete(); in_last.delete(); in_end.delete();
        add_mb420();
        build_model(4);
        run_stream(1'b0, 1'b0, 1'b0);
        compare_all("t1");
        chk("t1_b0_l15", lane(out_data[0], 15), 'h10);
        chk("t1_cb_l0", lane(out_data[24], 0), 'h10);
        chk("t1_cb_l1", lane(out_data[24], 1), 'h20);
        chk("t1_cb_l2", lane(out_data[24], 2), 'h30);
        chk("t1_cb_l3", lane(out_data[24], 3), 'h40);
        chk("t1_cb_l4", lane(out_data[24], 4), 0);
        chk("t1_cr_l0", lane(out_data[25], 0), 'h800);
        chk("t1_cr_l3", lane(out_data[25], 3), 'h800);
        chk("t1_cr_l4", lane(out_data[25], 4), 0);
        chk("t1_last_pos", int'(out_last[25]), 1);
        chk("t1_last_cnt", count_last(), 1);
        chk("t1_sync_err", serr_cnt, 0);
        chk("t1_sready_dc", sready_bad, 0);

        // 2: same MB with back-pressure and gaps; mode_422 toggled after block 0
        run_stream(1'b1, 1'b0, 1'b1);
        compare_all("t2");
        chk("t2_sready_dc", sready_bad, 0);
        chk("t2_last_cnt", count_last(), 1);
        chk("t2_sync_err", serr_cnt, 0);

        // 3: 4:2:2, all pels 0xFF
        in_data.delete(); in_last.delete(); in_end.delete();
        for (int i = 0; i < 32; i++) add_beat(blk(8'hFF), (i == 31), (i == 31));
        build_model(8);
        run_stream(1'b0, 1'b1, 1'b1);
        compare_all("t3");
        chk("t3_cb_l0", lane(out_data[32], 0), 'hFF0);
        chk("t3_cb_l7", lane(out_data[32], 7), 'hFF0);
        chk("t3_cb_l8", lane(out_data[32], 8), 0);
        chk("t3_cr_l7", lane(out_data[33], 7), 'hFF0);
        chk("t3_cr_l15", lane(out_data[33], 15), 0);
        chk("t3_last", int'(out_last[33]), 1);
        chk("t3_sync_err", serr_cnt, 0);

        // 4: early s_last on beat 20, then a normal MB
        in_data.delete(); in_last.delete(); in_end.delete();
        for (int i = 0; i < 16; i++) add_beat(blk(8'h10), 1'b0, 1'b0);
        for (int k = 0; k < 4; k++)  add_beat(blk(8'(k + 1)), 1'b0, 1'b0);
        add_beat(blk(8'h80), 1'b1, 1'b1);
        build_model(4);
        run_stream(1'b0, 1'b0, 1'b0);
        compare_all("t4a");
        chk("t4_sync_err_cnt", serr_cnt, 1);
        chk("t4_cb_l3", lane(out_data[21], 3), 'h40);
        chk("t4_cr_l0", lane(out_data[22], 0), 'h800);
        chk("t4_cr_l1", lane(out_data[22], 1), 0);
        chk("t4_cr_l3", lane(out_data[22], 3), 0);
        chk("t4_cr_last", int'(out_last[22]), 1);
        in_data.delete(); in_last.delete(); in_end.delete();
        add_mb420();
        build_model(4);
        run_stream(1'b0, 1'b0, 1'b0);
        compare_all("t4b");
        chk("t4b_sync_err", serr_cnt, 0);

        // 5: reset mid-MB with a beat pending on the output
        m_ready = 1'b1; mode_422 = 1'b0;
        for (int i = 0; i < 10; i++) begin
            s_valid = 1'b1; s_data = blk(8'h33); s_last = 1'b0;
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
        chk("t5_pre_m_valid", int'(m_valid), 1);
        reset_n = 1'b0;
        #1;
        chk("t5_rst_m_valid", int'(m_valid), 0);
        chk("t5_rst_m_data", lane(m_data, 0), 0);
        chk("t5_rst_m_last", int'(m_last), 0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        in_data.delete(); in_last.delete(); in_end.delete();
        add_mb420();
        build_model(4);
        run_stream(1'b0, 1'b0, 1'b0);
        compare_all("t5");
        chk("t5_cr_l0", lane(out_data[25], 0), 'h800);
        chk("t5_sync_err", serr_cnt, 0);

        // 6: three back-to-back MBs at full rate
        in_data.delete(); in_last.delete(); in_end.delete();
        add_mb420(); add_mb420(); add_mb420();
        build_model(4);
        run_stream(1'b0, 1'b0, 1'b0);
        compare_all("t6");
        chk("t6_span", out_tick[77] - first_acc, 78);
        chk("t6_first_lat", out_tick[0] - first_acc, 1);
        chk("t6_last25", int'(out_last[25]), 1);
        chk("t6_last51", int'(out_last[51]), 1);
        chk("t6_last77", int'(out_last[77]), 1);
        chk("t6_last_cnt", count_last(), 3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
